// File: rtl/mdio_responder_if.sv
// Management bus bundle for the MDIO responder: MDC/MDIO pins, write notification
// and the user-side register read port.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic [15:0] stat_in;
  logic        reg_wr_strobe;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic [4:0]  usr_addr;
  logic [15:0] usr_rddata;

  modport master (
    output mdc, mdio_in, stat_in, usr_addr,
    input  mdio_out, mdio_oen, reg_wr_strobe, reg_wr_addr, reg_wr_data, usr_rddata
  );

  modport slave (
    input  mdc, mdio_in, stat_in, usr_addr,
    output mdio_out, mdio_oen, reg_wr_strobe, reg_wr_addr, reg_wr_data, usr_rddata
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on clk, decodes read/write frames
// and serves a small register file with live status and PHY ID registers.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1556,
  parameter logic [15:0] CTRL_DEFAULT = 16'h1140
) (
  input  logic            clk,
  input  logic            reset,
  mdio_responder_if.slave bus
);

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned K_W       = 5;
  localparam int unsigned REG_SLOTS = 32;

  localparam logic [CNT_W-1:0] PRE_SAT = CNT_W'(32);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ST1   = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam logic [K_W-1:0] K_OP_END     = 5'd1;
  localparam logic [K_W-1:0] K_PHY_FIRST  = 5'd2;
  localparam logic [K_W-1:0] K_PHY_END    = 5'd6;
  localparam logic [K_W-1:0] K_REG_FIRST  = 5'd7;
  localparam logic [K_W-1:0] K_REG_END    = 5'd11;
  localparam logic [K_W-1:0] K_TA_FIRST   = 5'd12;
  localparam logic [K_W-1:0] K_TA_END     = 5'd13;
  localparam logic [K_W-1:0] K_DATA_FIRST = 5'd14;
  localparam logic [K_W-1:0] K_DRIVE_END  = 5'd28;
  localparam logic [K_W-1:0] K_LAST       = 5'd29;

  // Synchronizers and edge detect
  logic mdc_meta, mdc_sync, mdc_prev;
  logic mdio_meta, mdio_sync;

  logic              mdc_rise_c;
  logic              bit_c;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] phyad_q, phyad_d;
  logic [ADDR_W-1:0] regad_q, regad_d;
  logic [1:0]        ta_q, ta_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
  logic              mdio_out_q, mdio_out_d;
  logic              mdio_oen_q, mdio_oen_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] usr_rddata_q, usr_rddata_d;
  logic [DATA_W-1:0] regs_q [REG_SLOTS];
  logic [DATA_W-1:0] regs_d [REG_SLOTS];

  logic [1:0]        op_full_c;
  logic [ADDR_W-1:0] regad_full_c;
  logic [DATA_W-1:0] wdata_full_c;
  logic              addr_match_c;

  function automatic logic is_rw(input logic [ADDR_W-1:0] a);
    return (a == 5'd0) || ((a >= 5'd4) && (32'(a) < NUM_REGS));
  endfunction

  // Register map shared by the MDIO read path and the user read port
  function automatic logic [DATA_W-1:0] read_map(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    case (a)
      5'd1:    v = bus.stat_in;
      5'd2:    v = PHY_ID1;
      5'd3:    v = PHY_ID2;
      default: v = (32'(a) < NUM_REGS) ? regs_q[a] : '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_meta  <= 1'b0;
      mdc_sync  <= 1'b0;
      mdc_prev  <= 1'b0;
      mdio_meta <= 1'b1;
      mdio_sync <= 1'b1;
    end else begin
      mdc_meta  <= bus.mdc;
      mdc_sync  <= mdc_meta;
      mdc_prev  <= mdc_sync;
      mdio_meta <= bus.mdio_in;
      mdio_sync <= mdio_meta;
    end
  end

  assign mdc_rise_c   = mdc_sync & ~mdc_prev;
  assign bit_c        = mdio_sync;
  assign op_full_c    = {op_q[0], bit_c};
  assign regad_full_c = {regad_q[ADDR_W-2:0], bit_c};
  assign wdata_full_c = {wdata_q[DATA_W-2:0], bit_c};
  assign addr_match_c = (phyad_q == PHY_ADDR);

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      k_q          <= '0;
      op_q         <= '0;
      phyad_q      <= '0;
      regad_q      <= '0;
      ta_q         <= '0;
      wdata_q      <= '0;
      rd_shift_q   <= '0;
      mdio_out_q   <= 1'b1;
      mdio_oen_q   <= 1'b1;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      usr_rddata_q <= '0;
      for (int unsigned i = 0; i < REG_SLOTS; i++) regs_q[i] <= CTRL_DEFAULT;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      k_q          <= k_d;
      op_q         <= op_d;
      phyad_q      <= phyad_d;
      regad_q      <= regad_d;
      ta_q         <= ta_d;
      wdata_q      <= wdata_d;
      rd_shift_q   <= rd_shift_d;
      mdio_out_q   <= mdio_out_d;
      mdio_oen_q   <= mdio_oen_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      usr_rddata_q <= usr_rddata_d;
      regs_q       <= regs_d;
    end
  end

  // Frame decoder: all protocol decisions happen in the MDC edge-detect cycle
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    k_d          = k_q;
    op_d         = op_q;
    phyad_d      = phyad_q;
    regad_d      = regad_q;
    ta_d         = ta_q;
    wdata_d      = wdata_q;
    rd_shift_d   = rd_shift_q;
    mdio_out_d   = mdio_out_q;
    mdio_oen_d   = mdio_oen_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;
    // Reads regs_q, so a same-cycle write returns the old value
    usr_rddata_d = read_map(bus.usr_addr);

    if (mdc_rise_c) begin
      case (state_q)
        S_IDLE: begin
          if (bit_c) begin
            if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + CNT_W'(1);
          end else begin
            if (pre_cnt_q == PRE_SAT) state_d = S_ST1;
            pre_cnt_d = '0;
          end
        end

        S_ST1: begin
          if (bit_c) begin
            state_d = S_FRAME;
            k_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_FRAME: begin
          k_d = k_q + K_W'(1);

          if (k_q <= K_OP_END) op_d = op_full_c;
          if ((k_q == K_OP_END) && (op_full_c != OP_WRITE) && (op_full_c != OP_READ))
            state_d = S_IDLE;
          if ((k_q >= K_PHY_FIRST) && (k_q <= K_PHY_END))
            phyad_d = {phyad_q[ADDR_W-2:0], bit_c};
          if ((k_q >= K_REG_FIRST) && (k_q <= K_REG_END)) regad_d = regad_full_c;
          if (k_q == K_REG_END) rd_shift_d = read_map(regad_full_c);
          if ((k_q >= K_TA_FIRST) && (k_q <= K_TA_END)) ta_d = {ta_q[0], bit_c};
          if (k_q >= K_DATA_FIRST) wdata_d = wdata_full_c;

          // Take the line for the second TA bit, then shift data out MSB first
          if ((op_q == OP_READ) && addr_match_c) begin
            if (k_q == K_TA_FIRST) begin
              mdio_oen_d = 1'b0;
              mdio_out_d = 1'b0;
            end else if ((k_q >= K_TA_END) && (k_q <= K_DRIVE_END)) begin
              mdio_out_d = rd_shift_q[DATA_W-1];
              rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
            end
          end

          if (k_q == K_LAST) begin
            state_d    = S_IDLE;
            mdio_oen_d = 1'b1;
            mdio_out_d = 1'b1;
            if ((op_q == OP_WRITE) && addr_match_c && (ta_q == TA_WRITE)) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = regad_q;
              wr_data_d   = wdata_full_c;
              if (regad_q == 5'd0) begin
                // Bit 15 of reg 0 is a self-clearing soft reset of all RW registers
                if (wdata_full_c[DATA_W-1]) begin
                  for (int unsigned i = 0; i < REG_SLOTS; i++) regs_d[i] = CTRL_DEFAULT;
                end else begin
                  regs_d[0] = {1'b0, wdata_full_c[DATA_W-2:0]};
                end
              end else if (is_rw(regad_q)) begin
                regs_d[regad_q] = wdata_full_c;
              end
            end
          end
        end

        default: begin
          state_d   = S_IDLE;
          pre_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.mdio_out      = mdio_out_q;
  assign bus.mdio_oen      = mdio_oen_q;
  assign bus.reg_wr_strobe = wr_strobe_q;
  assign bus.reg_wr_addr   = wr_addr_q;
  assign bus.reg_wr_data   = wr_data_q;
  assign bus.usr_rddata    = usr_rddata_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: directed test-plan frames plus randomized frames checked
// against a register-map reference model.
module tb_mdio_responder;
  localparam logic [4:0]  PHY  = 5'd1;
  localparam int          NREG = 8;
  localparam logic [15:0] ID1  = 16'h0022;
  localparam logic [15:0] ID2  = 16'h1556;
  localparam logic [15:0] DEF  = 16'h1140;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdio_responder_if bus ();

  mdio_responder #(
    .PHY_ADDR(PHY), .NUM_REGS(NREG), .PHY_ID1(ID1), .PHY_ID2(ID2), .CTRL_DEFAULT(DEF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          strobe_cnt = 0;
  logic [15:0] strobe_usr = '0;
  logic [15:0] mreg [NREG];

  // Count strobe cycles and capture the user read data seen during the strobe
  always @(negedge clk) begin
    if (bus.reg_wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_usr = bus.usr_rddata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = DEF;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a, input logic [15:0] st);
    if (a == 5'd1) return st;
    if (a == 5'd2) return ID1;
    if (a == 5'd3) return ID2;
    if (int'(a) >= NREG) return 16'h0000;
    return mreg[a];
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) begin
      if (d[15]) model_reset();
      else mreg[0] = d & 16'h7FFF;
    end else if (int'(a) >= 4 && int'(a) < NREG) begin
      mreg[a] = d;
    end
  endtask

  // One MDC period; o/e are the line state the master sees at this rising edge
  task automatic send_bit(input logic b, output logic o, output logic e);
    bus.mdio_in = b;
    repeat (4) @(negedge clk);
    o = bus.mdio_out;
    e = bus.mdio_oen;
    bus.mdc = 1'b1;
    repeat (4) @(negedge clk);
    bus.mdc = 1'b0;
  endtask

  task automatic run_frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                           input logic [15:0] wd, input int rst_at);
    logic [29:0] bits, oen_seen, out_seen, exp_oen;
    logic [15:0] exp_rd, got_rd, old_val;
    logic        o, e;
    bit          valid, drive, wr;
    int          strobes0;
    bits     = {op, phy, ra, ta, wd};
    valid    = (npre >= 32) && (st == 2'b01) && (op == 2'b01 || op == 2'b10);
    drive    = valid && (op == 2'b10) && (phy == PHY);
    wr       = valid && (op == 2'b01) && (phy == PHY) && (ta == 2'b10);
    bus.usr_addr = ra;
    old_val  = model_read(ra, bus.stat_in);
    exp_rd   = old_val;
    strobes0 = strobe_cnt;
    oen_seen = '1;
    out_seen = '1;

    send_bit(1'b0, o, e);
    repeat (npre) send_bit(1'b1, o, e);
    send_bit(st[1], o, e);
    send_bit(st[0], o, e);
    for (int k = 0; k < 30; k++) begin
      if (k == rst_at) begin
        check("pre_reset_oen", 32'(bus.mdio_oen), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_oen", 32'(bus.mdio_oen), 32'd1);
        check("reset_out", 32'(bus.mdio_out), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive = 1'b0;
        wr    = 1'b0;
      end
      send_bit(bits[29-k], o, e);
      oen_seen[k] = e;
      out_seen[k] = o;
    end
    repeat (8) @(negedge clk);

    if (rst_at < 0) begin
      for (int k = 0; k < 30; k++) exp_oen[k] = !(drive && k >= 13);
      check("oen_pattern", 32'(oen_seen), 32'(exp_oen));
    end
    check("oen_released", 32'(bus.mdio_oen), 32'd1);
    check("strobe_count", 32'(strobe_cnt - strobes0), wr ? 32'd1 : 32'd0);
    if (drive) begin
      got_rd = '0;
      for (int k = 14; k < 30; k++) got_rd = {got_rd[14:0], out_seen[k]};
      check("ta_drive_low", 32'(out_seen[13]), 32'd0);
      check("rd_data", 32'(got_rd), 32'(exp_rd));
    end
    if (wr) begin
      check("wr_addr", 32'(bus.reg_wr_addr), 32'(ra));
      check("wr_data", 32'(bus.reg_wr_data), 32'(wd));
      check("usr_during_wr", 32'(strobe_usr), 32'(old_val));
      model_write(ra, wd);
    end
    check("usr_rd", 32'(bus.usr_rddata), 32'(model_read(ra, bus.stat_in)));
  endtask

  initial begin
    int          npre;
    logic [1:0]  op, ta;
    logic [4:0]  phy, ra;

    bus.mdc      = 1'b0;
    bus.mdio_in  = 1'b1;
    bus.stat_in  = 16'h786D;
    bus.usr_addr = 5'd0;
    reset        = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mdio_out", 32'(bus.mdio_out), 32'd1);
    check("rst_mdio_oen", 32'(bus.mdio_oen), 32'd1);
    check("rst_strobe", 32'(bus.reg_wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(bus.reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.reg_wr_data), 32'd0);
    check("rst_usr_rddata", 32'(bus.usr_rddata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("usr_reg0_default", 32'(bus.usr_rddata), 32'(DEF));

    // Basic write then read-back over MDIO
    run_frame(32, 2'b01, 2'b01, PHY, 5'd4, 2'b10, 16'hA5C3, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd4, 2'b11, 16'hFFFF, -1);
    // Status, ID and unimplemented registers
    run_frame(32, 2'b01, 2'b10, PHY, 5'd1, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd2, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd3, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd9, 2'b11, 16'hFFFF, -1);
    // Foreign PHY address, then a valid frame right after
    run_frame(32, 2'b01, 2'b10, 5'd2, 5'd4, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b01, 5'd2, 5'd4, 2'b10, 16'h1234, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd4, 2'b11, 16'hFFFF, -1);
    // Aborted frames, each followed by a valid read
    run_frame(31, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'hBEEF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b00, 2'b01, PHY, 5'd5, 2'b10, 16'hBEEF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b11, PHY, 5'd5, 2'b10, 16'hBEEF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b01, PHY, 5'd5, 2'b11, 16'hBEEF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b11, 16'hFFFF, -1);
    // Write to read-only register: strobe fires, storage unchanged
    run_frame(32, 2'b01, 2'b01, PHY, 5'd2, 2'b10, 16'h4321, -1);
    // Soft reset through reg 0 bit 15
    run_frame(32, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h0001, -1);
    run_frame(32, 2'b01, 2'b01, PHY, 5'd0, 2'b10, 16'h8000, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd0, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b11, 16'hFFFF, -1);

    // User read port sweep with one-cycle latency
    for (int a = 0; a < 10; a++) begin
      bus.usr_addr = 5'(a);
      @(negedge clk);
      check("usr_sweep", 32'(bus.usr_rddata), 32'(model_read(5'(a), bus.stat_in)));
    end

    // Randomized frames
    for (int i = 0; i < 30; i++) begin
      bus.stat_in = 16'($urandom);
      npre = ($urandom_range(0, 7) == 0) ? 31 : 32 + int'($urandom_range(0, 3));
      op   = ($urandom_range(0, 9) == 0) ? 2'b11 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      phy  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY;
      ra   = 5'($urandom_range(0, 11));
      ta   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b10;
      run_frame(npre, 2'b01, op, phy, ra, ta, 16'($urandom), -1);
    end

    // Reset in the middle of a read data phase
    run_frame(32, 2'b01, 2'b01, PHY, 5'd6, 2'b10, 16'h5A5A, -1);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd6, 2'b11, 16'hFFFF, 21);
    run_frame(32, 2'b01, 2'b10, PHY, 5'd6, 2'b11, 16'hFFFF, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side MDIO/MIIM management responder: the target end of the MDC/MDIO bus that the MAC's MIIM master drives.
- Oversamples MDC and MDIO on the system clock, decodes IEEE 802.3 clause-22 frames, and serves a small register file.
- Used in the bridge testbench PHY model and in the FPGA loopback PHY emulator.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- NUM_REGS, 8, number of implemented register addresses (0..NUM_REGS-1, range 4..32).
- PHY_ID1, 16'h0022, read-only value returned for register 2.
- PHY_ID2, 16'h1556, read-only value returned for register 3.
- CTRL_DEFAULT, 16'h1140, reset value of register 0 and of registers 4..NUM_REGS-1.

Ports:
- clk  in  1  system clock; frequency at least 4x MDC.
- reset  in  1  asynchronous, active-high reset.
- mdc  in  1  management clock from the MIIM master, asynchronous to clk.
- mdio_in  in  1  MDIO line value.
- mdio_out  out  1  MDIO drive value.
- mdio_oen  out  1  active-low output enable; the tristate drives mdio_out only when mdio_oen=0.
- stat_in  in  16  live status word returned for register 1 (read-only).
- reg_wr_strobe  out  1  one-cycle pulse on a completed valid write.
- reg_wr_addr  out  5  register address of the last write.
- reg_wr_data  out  16  data of the last write.
- usr_addr  in  5  user-side register read address.
- usr_rddata  out  16  user-side read data, registered with 1-cycle latency.

Behaviour:
- Reset values:
  - mdio_out=1, mdio_oen=1, reg_wr_strobe=0, reg_wr_addr=0, reg_wr_data=0, usr_rddata=0.
  - FSM in IDLE with the preamble counter at 0.
  - Registers 0 and 4..NUM_REGS-1 at CTRL_DEFAULT.
- Input sampling:
  - mdc and mdio_in each pass a 2-flop synchronizer.
  - A rising edge is detected when the synced mdc is 1 and its previous synced value was 0.
  - All protocol sampling uses the synced mdio value in the edge-detect cycle.
  - Outputs update on the next clk edge after the edge-detect cycle.
- Preamble:
  - In IDLE, a 6-bit counter counts consecutive sampled 1s and saturates at 32.
  - A sampled 0 resets the counter to 0.
  - A 0 sampled with the counter at 32 is ST bit 0; go to ST1.
- ST1: sample 1 -> OP. Sample 0 -> IDLE, counter cleared.
- Frame bits after ST are indexed k=0..29:
  - k=0..1 OP: 01 = write, 10 = read, anything else -> IDLE.
  - k=2..6 PHYAD, MSB first.
  - k=7..11 REGAD, MSB first.
  - k=12..13 TA.
  - k=14..29 DATA, bit 15 first.
- Address match:
  - PHYAD != PHY_ADDR: the FSM keeps counting to k=29 without driving or writing, then returns to IDLE.
- Read with match:
  - At edge k=11, latch read data:
    - regs 0 and 4..NUM_REGS-1: stored value;
    - reg 1: stat_in;
    - reg 2: PHY_ID1;
    - reg 3: PHY_ID2;
    - REGAD >= NUM_REGS: 16'h0000.
  - Edge k=12: drive mdio_oen=0, mdio_out=0 (second TA bit). TA bit 1 stays Z.
  - Edges k=13..28: drive data bits 15..0 in order.
  - Edge k=29: mdio_oen=1, mdio_out=1, FSM -> IDLE.
- Write with match:
  - TA sampled at k=12,13 must be 1,0; otherwise suppress the write and finish the frame silently.
  - After the edge sampling k=29: pulse reg_wr_strobe for 1 cycle and update reg_wr_addr/reg_wr_data.
  - Update the register only for addresses 0 and 4..NUM_REGS-1. Addresses 1-3 and >= NUM_REGS: strobe still fires, but no storage changes.
  - Writing reg 0 with bit 15 = 1 reloads all RW registers to CTRL_DEFAULT; reg 0 bit 15 reads back as 0 (self-clearing).
- End of frame: every frame, completed or aborted, returns to IDLE with the counter at 0. A new frame therefore needs 32 fresh preamble 1s; there is no preamble suppression.
- Reset mid-frame: immediately mdio_oen=1, FSM to IDLE, no write.
- User read port: usr_rddata uses the same mapping as an MDIO read.
  - On a usr_addr read coinciding with a write to the same address, return the old value.

Test Plan:
- Write frame: 32x1, ST 01, OP 01, PHYAD 00001, REGAD 00100, TA 10, data 16'hA5C3 -> one reg_wr_strobe pulse, reg_wr_addr=4, reg_wr_data=16'hA5C3; usr_addr=4 returns 16'hA5C3 one cycle later.
- Read frame: same header, OP 10, REGAD 00100 -> mdio_oen low from edge k=12 to k=28; serial bits 0 then 1010010111000011; released at k=29.
- Read regs 1/2/3 with stat_in=16'h786D -> returns 16'h786D, 16'h0022, 16'h1556. Read REGAD 9 -> 16'h0000.
- PHYAD 00010 mismatch on a read or write -> mdio_oen stays 1 for the whole frame, no strobe; an immediately following valid frame is accepted.
- Abort cases -> no drive, no write, next valid frame works:
  - only 31 preamble 1s;
  - ST 00;
  - OP 11;
  - write TA 11.
- Write reg 0 with 16'h8000 after reg 5 was written 16'h0001 -> reg 0 reads 16'h1140 and reg 5 reads 16'h1140. Assert reset at read data bit k=20 -> mdio_oen=1 within 1 cycle.
